// File: rtl/prime_range_scanner.sv
// prime_range_scanner
//
// Walks every value of an inclusive range [lo, hi] and tests each one for
// primality by repeated trial division. It uses a restoring divider that
// produces one quotient bit per cycle. Primes leave in ascending order on a
// valid/ready stream.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        one-cycle scan request, only honoured while idle
//   lo, hi       inclusive bounds, captured when start is accepted
//   prime_out    current prime, meaningful only while prime_valid is high
//   prime_valid  prime_out holds a prime waiting to be accepted
//   prime_ready  downstream takes prime_out when high together with prime_valid
//   busy         high in every state except idle
//   done         one-cycle pulse at the end of a scan
//   prime_count  primes handed off in the current or most recent scan
module prime_range_scanner #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] prime_out,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prime_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DIV, S_CHECK, S_EMIT, S_NEXT, S_DONE
  } state_t;

  localparam int               DIV_LAST_I = WIDTH - 1;
  localparam logic [WIDTH-1:0] DIV_LAST   = DIV_LAST_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TWO        = ONE << 1;

  state_t state, state_nx;

  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   cur;
  logic [WIDTH-1:0]   d;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   div_cnt;
  logic [WIDTH-1:0]   count_q;
  // One extra bit so the shifted partial remainder cannot overflow.
  logic [WIDTH:0]     rem;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] d_plus;
  logic [2*WIDTH-1:0] d_plus_sq;
  logic               rem_zero;
  logic               sq_exceeds;
  logic               cur_small;
  logic               cur_2_3;
  logic               div_last;

  // Shared datapath decisions.
  // The divisor bound is tested as (d+1)^2 > cur at double width, so no
  // square root is needed and the product cannot overflow.
  always_comb begin
    trial      = {rem[WIDTH-1:0], dividend[WIDTH-1]};
    d_plus     = {{WIDTH{1'b0}}, d} + {{(2*WIDTH-1){1'b0}}, 1'b1};
    d_plus_sq  = d_plus * d_plus;
    sq_exceeds = d_plus_sq > {{WIDTH{1'b0}}, cur};
    rem_zero   = (rem == '0);
    cur_small  = (cur[WIDTH-1:1] == '0);
    cur_2_3    = (cur[WIDTH-1:2] == '0) && cur[1];
    div_last   = (div_cnt == DIV_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (lo <= hi) ? S_LOAD : S_DONE;
      S_LOAD: begin
        if      (cur_small) state_nx = S_NEXT;
        else if (cur_2_3)   state_nx = S_EMIT;
        else                state_nx = S_DIV;
      end
      S_DIV:   if (div_last) state_nx = S_CHECK;
      S_CHECK: begin
        if      (rem_zero)   state_nx = S_NEXT;
        else if (sq_exceeds) state_nx = S_EMIT;
        else                 state_nx = S_DIV;
      end
      S_EMIT:  if (prime_ready) state_nx = S_NEXT;
      S_NEXT:  state_nx = (cur == hi_q) ? S_DONE : S_LOAD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath registers.
  // Entering a division always reloads the dividend from cur and clears the
  // remainder. Both LOAD and the CHECK-to-DIV path do this.
  // NEXT compares cur with hi before incrementing, so a top-of-range hi never
  // wraps cur back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      cur      <= '0;
      d        <= '0;
      dividend <= '0;
      div_cnt  <= '0;
      rem      <= '0;
      count_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count_q <= '0;
            if (lo <= hi) begin
              cur  <= lo;
              hi_q <= hi;
            end
          end
        end
        S_LOAD: begin
          d        <= TWO;
          rem      <= '0;
          dividend <= cur;
          div_cnt  <= '0;
        end
        S_DIV: begin
          rem      <= (trial >= {1'b0, d}) ? (trial - {1'b0, d}) : trial;
          dividend <= dividend << 1;
          div_cnt  <= div_cnt + ONE;
        end
        S_CHECK: begin
          if (!rem_zero && !sq_exceeds) begin
            d        <= d + ONE;
            rem      <= '0;
            dividend <= cur;
            div_cnt  <= '0;
          end
        end
        S_EMIT:  if (prime_ready) count_q <= count_q + ONE;
        S_NEXT:  if (cur != hi_q) cur <= cur + ONE;
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    prime_valid = (state == S_EMIT);
    prime_out   = (state == S_EMIT) ? cur : '0;
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    prime_count = count_q;
  end

endmodule
